mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a data-memory handshake and a hardware call/return stack.
//
// Each live instruction is priority-decoded: call > ret > pop > MemRead/MemWrite.
// Memory ops move IDLE -> ACCESS and stall upstream until mem_ack. Everything else
// passes through to MEM/WB one cycle later. The stack pointer (SP) starts at STACK_TOP
// and grows downward. A call writes PC_in at SP-1. A ret or pop reads at SP.
//
// Optional feature macro: STACK_CHECK_EN
//   When defined, overflow/underflow is detected: a call at STACK_LIMIT, or a ret/pop at
//   STACK_TOP. Such an op is dropped (no request, no writeback, no stall) and sets the
//   sticky stack_err flag.
//   When undefined, SP wraps modulo 2^32 and stack_err is tied to 0.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   valid_in + control/data      EX/MEM slot contents (held stable while mem_stall=1)
//   mem_req/we/addr/wdata        data-memory request (registered, held during ACCESS)
//   mem_rdata, mem_ack           memory response
//   mem_stall                    upstream freeze
//   wb_valid, RegWrite_out,
//   DestReg_out, wb_data         MEM/WB outputs
//   ret_valid, ret_target        one-cycle return redirect to fetch
//   stack_err                    sticky stack overflow/underflow flag
module mem_stage #(
    parameter logic [31:0] STACK_TOP   = 32'h0000_0400,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic        MemSrc_in,
    input  logic        call_in,
    input  logic        ret_in,
    input  logic        pop_in,
    input  logic [4:0]  DestReg_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] MemWrite_data_in,
    input  logic [31:0] PC_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        RegWrite_out,
    output logic [4:0]  DestReg_out,
    output logic [31:0] wb_data,
    output logic        ret_valid,
    output logic [31:0] ret_target,
    output logic        stack_err
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_sp;
    logic        r_mem_req, r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic        r_wb_valid, r_regwrite, r_ret_valid;
    logic [4:0]  r_dest;
    logic [31:0] r_wb_data, r_ret_target;

    logic        w_is_call, w_is_ret, w_is_pop, w_is_data, w_is_store;
    logic        w_any_mem, w_fault, w_mem_op;
    logic        w_we;
    logic [31:0] w_addr, w_wdata;

    // Priority decode: a higher-priority bit masks every lower one.
    assign w_is_call  = call_in;
    assign w_is_ret   = ~call_in & ret_in;
    assign w_is_pop   = ~call_in & ~ret_in & pop_in;
    assign w_is_data  = ~call_in & ~ret_in & ~pop_in;
    // A plain data op with both MemRead and MemWrite set is treated as a load.
    assign w_is_store = w_is_data & ~MemRead_in & MemWrite_in;
    assign w_any_mem  = valid_in & (call_in | ret_in | pop_in | MemRead_in | MemWrite_in);

`ifdef STACK_CHECK_EN
    logic r_stack_err;
    assign w_fault = valid_in & ((w_is_call & (r_sp == STACK_LIMIT)) |
                                 ((w_is_ret | w_is_pop) & (r_sp == STACK_TOP)));
    assign stack_err = r_stack_err;
`else
    // STACK_LIMIT only matters when checking is enabled.
    logic w_unused_limit;
    assign w_unused_limit = (r_sp == STACK_LIMIT);
    assign w_fault   = 1'b0;
    assign stack_err = 1'b0;
`endif

    assign w_mem_op = w_any_mem & ~w_fault;

    assign w_addr  = w_is_call                             ? r_sp - 32'd1 :
                     (w_is_ret | w_is_pop | MemSrc_in)     ? r_sp         : alu_result_in;
    assign w_we    = w_is_call | w_is_store;
    assign w_wdata = w_is_call ? PC_in : MemWrite_data_in;

    // Gating with rst_n means an abandoned ACCESS never stalls upstream during reset.
    assign mem_stall = rst_n & (((r_state == StIdle) & w_mem_op) |
                                ((r_state == StAccess) & ~mem_ack));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_mem_op) w_state_next = StAccess;
            StAccess: if (mem_ack)  w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_sp         <= STACK_TOP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_wb_valid   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_dest       <= '0;
            r_wb_data    <= '0;
            r_ret_valid  <= 1'b0;
            r_ret_target <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wb_valid  <= 1'b0;
            r_regwrite  <= 1'b0;
            r_ret_valid <= 1'b0;
            if (r_state == StIdle) begin
                if (w_mem_op) begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= w_we;
                    r_mem_addr  <= w_addr;
                    r_mem_wdata <= w_wdata;
                end else if (valid_in & ~w_fault) begin
                    r_wb_valid <= 1'b1;
                    r_regwrite <= RegWrite_in;
                    r_dest     <= DestReg_in;
                    r_wb_data  <= alu_result_in;
                end
            end else if (mem_ack) begin
                // Upstream held the instruction stable, so the decode still describes it.
                r_mem_req  <= 1'b0;
                r_mem_we   <= 1'b0;
                r_wb_valid <= 1'b1;
                r_regwrite <= RegWrite_in & ~w_is_call & ~w_is_ret & ~w_is_store;
                r_dest     <= DestReg_in;
                r_wb_data  <= (MemToReg_in | w_is_pop) ? mem_rdata : alu_result_in;
                if (w_is_ret) begin
                    r_ret_valid  <= 1'b1;
                    r_ret_target <= mem_rdata;
                end
                if (w_is_call) begin
                    r_sp <= r_sp - 32'd1;
                end else if (w_is_ret | w_is_pop) begin
                    r_sp <= r_sp + 32'd1;
                end
            end
        end
    end

`ifdef STACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stack_err <= 1'b0;
        end else if ((r_state == StIdle) && w_fault) begin
            r_stack_err <= 1'b1;
        end
    end
`endif

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign wb_valid     = r_wb_valid;
    assign RegWrite_out = r_regwrite;
    assign DestReg_out  = r_dest;
    assign wb_data      = r_wb_data;
    assign ret_valid    = r_ret_valid;
    assign ret_target   = r_ret_target;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized ops for mem_stage, compared
// against a stack/priority reference model kept in the bench.
module tb_mem_stage;

    localparam logic [31:0] Top   = 32'h0000_0400;
    localparam logic [31:0] Limit = 32'h0000_0300;
`ifdef STACK_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        MemRead_in = 1'b0, MemWrite_in = 1'b0, MemToReg_in = 1'b0;
    logic        RegWrite_in = 1'b0, MemSrc_in = 1'b0;
    logic        call_in = 1'b0, ret_in = 1'b0, pop_in = 1'b0;
    logic [4:0]  DestReg_in = '0;
    logic [31:0] alu_result_in = '0, MemWrite_data_in = '0, PC_in = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_stall, wb_valid, RegWrite_out, ret_valid, stack_err;
    logic [4:0]  DestReg_out;
    logic [31:0] wb_data, ret_target;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
        .RegWrite_in(RegWrite_in), .MemSrc_in(MemSrc_in),
        .call_in(call_in), .ret_in(ret_in), .pop_in(pop_in),
        .DestReg_in(DestReg_in), .alu_result_in(alu_result_in),
        .MemWrite_data_in(MemWrite_data_in), .PC_in(PC_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .RegWrite_out(RegWrite_out), .DestReg_out(DestReg_out),
        .wb_data(wb_data), .ret_valid(ret_valid), .ret_target(ret_target),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          call, ret, pop, rd, wr, m2r, rw, msrc;
        logic [4:0]  dest;
        logic [31:0] alu, sdata, pc;
    } op_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_sp = Top;
    bit          m_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0; RegWrite_in = 0;
        MemSrc_in = 0; call_in = 0; ret_in = 0; pop_in = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        m_sp  = Top;
        m_err = 1'b0;
    endtask

    // Issue one instruction, answer it after dly extra ACCESS cycles with read data rd.
    task automatic do_op(input op_t o, input int dly, input logic [31:0] rd);
        bit          is_call, is_ret, is_pop, is_ld, is_st, memop, fault, exp_we, exp_rw;
        logic [31:0] exp_addr, exp_wdata, exp_wbd;
        int          stalls;
        is_call = o.call;
        is_ret  = !o.call && o.ret;
        is_pop  = !o.call && !o.ret && o.pop;
        is_ld   = !(o.call || o.ret || o.pop) && o.rd;
        is_st   = !(o.call || o.ret || o.pop) && !o.rd && o.wr;
        memop   = is_call || is_ret || is_pop || is_ld || is_st;
        fault   = ChkEn && ((is_call && m_sp == Limit) || ((is_ret || is_pop) && m_sp == Top));
        exp_addr  = is_call ? m_sp - 32'd1 : (is_ret || is_pop || o.msrc) ? m_sp : o.alu;
        exp_we    = is_call || is_st;
        exp_wdata = is_call ? o.pc : o.sdata;
        exp_rw    = o.rw && !(is_call || is_ret || is_st);
        exp_wbd   = (memop && (o.m2r || is_pop)) ? rd : o.alu;

        valid_in = 1; call_in = o.call; ret_in = o.ret; pop_in = o.pop;
        MemRead_in = o.rd; MemWrite_in = o.wr; MemToReg_in = o.m2r; RegWrite_in = o.rw;
        MemSrc_in = o.msrc; DestReg_in = o.dest; alu_result_in = o.alu;
        MemWrite_data_in = o.sdata; PC_in = o.pc; mem_ack = 0;
        #1;
        if (memop && !fault) begin
            stalls = mem_stall ? 1 : 0;
            @(posedge clk); #1;
            for (int i = 0; i <= dly; i++) begin
                check_eq("mem_req_access", mem_req, 1);
                check_eq("mem_addr", mem_addr, exp_addr);
                check_eq("mem_we", mem_we, exp_we);
                if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
                check_eq("wb_valid_stall", wb_valid, 0);
                mem_ack   = (i == dly);
                mem_rdata = (i == dly) ? rd : $urandom;
                #1;
                if (mem_stall) stalls++;
                @(posedge clk); #1;
            end
            mem_ack = 0;
            check_eq("stall_cycles", stalls, dly + 1);
            check_eq("mem_req_done", mem_req, 0);
        end else begin
            check_eq("no_stall", mem_stall, 0);
            @(posedge clk); #1;
            check_eq("mem_req_idle", mem_req, 0);
        end
        clear_inputs();
        if (memop && !fault) begin
            if (is_call) m_sp = m_sp - 32'd1;
            else if (is_ret || is_pop) m_sp = m_sp + 32'd1;
        end
        if (fault) m_err = 1'b1;
        check_eq("wb_valid", wb_valid, fault ? 0 : 1);
        if (!fault) begin
            check_eq("RegWrite_out", RegWrite_out, exp_rw);
            check_eq("DestReg_out", DestReg_out, o.dest);
            check_eq("wb_data", wb_data, exp_wbd);
        end
        check_eq("ret_valid", ret_valid, (is_ret && !fault) ? 1 : 0);
        if (is_ret && !fault) check_eq("ret_target", ret_target, rd);
        check_eq("stack_err", stack_err, m_err);
        if (is_ret && !fault) begin
            @(posedge clk); #1;
            check_eq("ret_pulse_end", ret_valid, 0);
        end
    endtask

    initial begin
        op_t o;
        do_reset();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_regwrite", RegWrite_out, 0);
        check_eq("rst_dest", DestReg_out, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_ret_valid", ret_valid, 0);
        check_eq("rst_ret_target", ret_target, 0);
        check_eq("rst_stack_err", stack_err, 0);
        check_eq("rst_stall", mem_stall, 0);

        // ALU pass-through
        o = '0; o.alu = 32'h55; o.rw = 1; o.dest = 5'd3;
        do_op(o, 0, 32'h0);
        // Load acked on the 4th ACCESS cycle
        o = '0; o.rd = 1; o.m2r = 1; o.rw = 1; o.dest = 5'd7; o.alu = 32'h10;
        do_op(o, 3, 32'hABCD);
        // call then ret, each acked on its first ACCESS cycle
        o = '0; o.call = 1; o.pc = 32'h40; o.rw = 1; o.alu = 32'h9;
        do_op(o, 0, 32'h0);
        o = '0; o.ret = 1; o.rw = 1; o.pop = 1;
        do_op(o, 0, 32'h40);
        // SP readback through an SP-addressed load
        o = '0; o.rd = 1; o.msrc = 1; o.alu = 32'h77; o.dest = 5'd1;
        do_op(o, 0, 32'h1234);
        // pop at an empty stack, then observe SP
        o = '0; o.pop = 1; o.rw = 1; o.dest = 5'd2;
        do_op(o, 1, 32'hBEEF);
        o = '0; o.rd = 1; o.msrc = 1; o.m2r = 1; o.dest = 5'd4;
        do_op(o, 0, 32'h5);
        check_eq("stack_err_sticky", stack_err, m_err);

        // Reset during the ACCESS of a store; the late ack must be ignored
        o = '0; o.wr = 1; o.alu = 32'h20; o.sdata = 32'h1234;
        valid_in = 1; MemWrite_in = 1; alu_result_in = o.alu; MemWrite_data_in = o.sdata;
        @(posedge clk); #1;
        check_eq("rst_acc_req", mem_req, 1);
        clear_inputs();
        rst_n = 0;
        #1;
        check_eq("rst_acc_stall", mem_stall, 0);
        @(posedge clk); #1;
        check_eq("rst_acc_req_clr", mem_req, 0);
        check_eq("rst_acc_wbv", wb_valid, 0);
        rst_n = 1; m_sp = Top; m_err = 1'b0;
        mem_ack = 1;
        @(posedge clk); #1;
        check_eq("late_ack_req", mem_req, 0);
        check_eq("late_ack_wbv", wb_valid, 0);
        mem_ack = 0;
        o = '0; o.rd = 1; o.msrc = 1; o.dest = 5'd9;
        do_op(o, 0, 32'h0);

        // Randomized ops, with occasional idle cycles carrying a stray ack
        do_reset();
        for (int n = 0; n < 80; n++) begin
            o = '0;
            o.call  = ($urandom_range(0, 6) == 0);
            o.ret   = ($urandom_range(0, 6) == 0);
            o.pop   = ($urandom_range(0, 6) == 0);
            o.rd    = ($urandom_range(0, 3) == 0);
            o.wr    = !o.rd && ($urandom_range(0, 3) == 0);
            o.m2r   = $urandom_range(0, 1) == 1;
            o.rw    = $urandom_range(0, 1) == 1;
            o.msrc  = $urandom_range(0, 1) == 1;
            o.dest  = 5'($urandom);
            o.alu   = $urandom;
            o.sdata = $urandom;
            o.pc    = $urandom;
            do_op(o, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 4) == 0) begin
                mem_ack = $urandom_range(0, 1) == 1;
                #1;
                check_eq("idle_stall", mem_stall, 0);
                @(posedge clk); #1;
                check_eq("idle_wbv", wb_valid, 0);
                check_eq("idle_req", mem_req, 0);
                mem_ack = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
